// File: rtl/des_round_ctrl.sv
// Iterative DES controller: one Feistel round per clock over 16 rounds, with
// the key schedule rotating C/D in place (left for encrypt, right for decrypt).
module des_round_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [4:0]  round_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Permutation tables use DES numbering: entry 1 is the MSB of the source.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each S-box is four 16-nibble rows, row 0 in the most significant bits.
    localparam logic [255:0] SBOX [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    function automatic logic [63:0] do_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] do_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] do_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] do_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] do_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] do_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four the column.
    function automatic logic [31:0] do_sbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        int          sh;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            sh  = 4 * (63 - int'({six[5], six[0], six[4:1]}));
            y[5'(31 - 4 * b) -: 4] = 4'(SBOX[b] >> sh);
        end
        return y;
    endfunction

    function automatic logic [1:0] shift_of(input logic [4:0] i);
        return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic right,
                                          input logic [1:0] n);
        logic [27:0] y;
        y = v;
        if (n == 2'd1)      y = right ? {v[0],   v[27:1]} : {v[26:0], v[27]};
        else if (n == 2'd2) y = right ? {v[1:0], v[27:2]} : {v[25:0], v[27:26]};
        return y;
    endfunction

    logic [1:0]  state;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [4:0]  cnt;
    logic        dec;

    logic [1:0]  shamt;
    logic [27:0] c_use, d_use;
    logic [47:0] subkey;
    logic [31:0] r_nxt;

    // Decrypt walks the schedule backwards: PC-1 output already equals C16/D16,
    // so round 1 uses it as-is and later rounds undo the encrypt shift.
    always_comb begin
        shamt = 2'd0;
        if (!dec)             shamt = shift_of(cnt);
        else if (cnt != 5'd1) shamt = shift_of(5'd18 - cnt);
        c_use  = rot28(c, dec, shamt);
        d_use  = rot28(d, dec, shamt);
        subkey = do_pc2({c_use, d_use});
        r_nxt  = l ^ do_p(do_sbox(do_e(r) ^ subkey));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            cnt       <= '0;
            dec       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    {l, r} <= do_ip(in_data);
                    {c, d} <= do_pc1(in_key);
                    dec    <= in_decrypt;
                    cnt    <= 5'd1;
                    state  <= ST_ROUND;
                end
                ST_ROUND: begin
                    l <= r;
                    r <= r_nxt;
                    c <= c_use;
                    d <= d_use;
                    if (cnt == 5'(NUM_ROUNDS)) begin
                        // Output block is {R16, L16}: the last swap is undone.
                        out_data  <= do_fp({r_nxt, r});
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign round_idx = (state == ST_ROUND) ? cnt : 5'd0;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: known answers, timing, backpressure, reset cases
// and random blocks against a straightforward whole-block DES model.
module tb_des_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] in_key = '0;
    logic        in_decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        busy;
    logic [4:0]  round_idx;

    int vectors = 0;
    int miscompares = 0;
    int ridx_q[$];

    des_round_ctrl #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int IP_Q[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int FP_Q[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int PC1_Q[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
    int PC2_Q[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int E_Q[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_Q[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    logic [63:0] SB [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    // Result is right-aligned; table length gives the output width.
    function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int tab[$]);
        logic [63:0] y = '0;
        foreach (tab[j]) y = (y << 1) | ((x >> (win - tab[j])) & 64'd1);
        return y;
    endfunction

    function automatic logic [31:0] f_model(input logic [31:0] rr, input logic [47:0] k);
        logic [63:0] x;
        logic [63:0] s = '0;
        int six, row, col;
        x = perm(64'(rr), 32, E_Q) ^ 64'(k);
        for (int b = 0; b < 8; b++) begin
            six = int'((x >> (42 - 6 * b)) & 64'd63);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s = (s << 4) | ((SB[b][row] >> (4 * (15 - col))) & 64'd15);
        end
        return 32'(perm(s, 32, P_Q));
    endfunction

    // Standard textbook form: build all 16 subkeys, decrypt uses them reversed.
    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data,
                                              input logic dcr);
        logic [63:0] cd, lr;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [31:0] l, r, t;
        cd = perm(key, 64, PC1_Q);
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < ((i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2); s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = 48'(perm({8'd0, c, d}, 56, PC2_Q));
        end
        lr = perm(data, 64, IP_Q);
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ f_model(r, dcr ? ks[15 - i] : ks[i]);
            l = r;
            r = t;
        end
        return perm({r, l}, 64, FP_Q);
    endfunction

    // ---------------- stimulus helpers (observe only) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_block(input logic [63:0] key, input logic [63:0] data, input logic dcr,
                               output logic [63:0] res, output int lat, output bit tmo);
        @(negedge clk);
        in_data = data;
        in_key = key;
        in_decrypt = dcr;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        in_key = {$urandom, $urandom};
        in_decrypt = ~dcr;
        ridx_q.delete();
        res = '0;
        lat = 0;
        tmo = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            ridx_q.push_back(int'(round_idx));
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                res = out_data;
                tmo = 1'b0;
                break;
            end
        end
        if (!tmo) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({in_ready, busy, out_valid, round_idx} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b ov=%b ridx=%0d, want 1 0 0 0",
                     in_ready, busy, out_valid, round_idx);
        end
        vectors++;
        if (out_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
    endtask

    task automatic test_kat();
        logic [63:0] res;
        int lat;
        bit tmo, seq_ok;
        logic [63:0] kk [3] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h0E329232EA6D0D73};
        logic [63:0] dd [3] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405, 64'h8787878787878787};
        logic [63:0] ee [3] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF, 64'h0000000000000000};
        logic        mm [3] = '{1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 3; v++) begin
            drive_block(kk[v], dd[v], mm[v], res, lat, tmo);
            vectors++;
            if (tmo || res !== ee[v]) begin
                miscompares++;
                $display("FAIL kat%0d: got %h (timeout=%0d) want %h", v, res, tmo, ee[v]);
            end
            vectors++;
            if (lat != 16) begin
                miscompares++;
                $display("FAIL kat%0d_latency: got %0d want 16", v, lat);
            end
            seq_ok = (ridx_q.size() == 16);
            foreach (ridx_q[i]) if (ridx_q[i] != i + 1) seq_ok = 1'b0;
            vectors++;
            if (!seq_ok) begin
                miscompares++;
                $display("FAIL kat%0d_round_idx: got %p want 1..16", v, ridx_q);
            end
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL kat%0d_idle: got rdy=%b ov=%b want 1 0", v, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0, stable_ok = 1'b1;
        logic [63:0] exp = 64'h85E813540F0AB405;
        @(negedge clk);
        in_key = 64'h133457799BBCDFF1;
        in_data = 64'h0123456789ABCDEF;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_data = {$urandom, $urandom};
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #1 seen = out_valid;
        end
        vectors++;
        if (!seen || out_data !== exp) begin
            miscompares++;
            $display("FAIL bp_result: got %h valid=%b want %h", out_data, seen, exp);
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        vectors++;
        if (!stable_ok) begin
            miscompares++;
            $display("FAIL bp_hold: got ov=%b data=%h rdy=%b want 1 %h 0",
                     out_valid, out_data, in_ready, exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [63:0] res[$];
        bit switched = 1'b0;
        logic [63:0] k2 = 64'h0E329232EA6D0D73;
        logic [63:0] d2 = 64'h8787878787878787;
        @(negedge clk);
        in_key = 64'h133457799BBCDFF1;
        in_data = 64'h0123456789ABCDEF;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 80 && res.size() < 2; n++) begin
            if (in_ready && in_valid) acc.push_back(n);
            if (out_valid) res.push_back(out_data);
            @(negedge clk);
            if (acc.size() == 1 && !switched) begin
                in_key = k2;
                in_data = d2;
                switched = 1'b1;
            end
            if (acc.size() == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (acc.size() != 2 || acc[1] - acc[0] != 18) begin
            miscompares++;
            $display("FAIL b2b_spacing: got accepts %p want two, 18 apart", acc);
        end
        vectors++;
        if (res.size() != 2 || res[0] !== 64'h85E813540F0AB405 || res[1] !== 64'h0) begin
            miscompares++;
            $display("FAIL b2b_results: got %p want 85e813540f0ab405, 0", res);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0, spurious = 1'b0, tmo;
        logic [63:0] res;
        int lat;
        @(negedge clk);
        in_key = 64'h133457799BBCDFF1;
        in_data = 64'h0123456789ABCDEF;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 0; n < 30 && !hit; n++) begin
            if (round_idx == 5'd7) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (!hit || {in_ready, busy, out_valid, round_idx} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL rst_mid: got hit=%b rdy=%b busy=%b ov=%b ridx=%0d want 1 1 0 0 0",
                     hit, in_ready, busy, out_valid, round_idx);
        end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1 if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        vectors++;
        if (spurious) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got activity after reset, want none");
        end
        drive_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, res, lat, tmo);
        vectors++;
        if (tmo || res !== 64'h85E813540F0AB405) begin
            miscompares++;
            $display("FAIL rst_mid_fresh: got %h want 85e813540f0ab405", res);
        end
    endtask

    task automatic test_reset_done();
        bit seen = 1'b0;
        @(negedge clk);
        in_key = 64'h133457799BBCDFF1;
        in_data = 64'h0123456789ABCDEF;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #1 seen = out_valid;
        end
        @(negedge clk);
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (!seen || out_valid !== 1'b0 || out_data !== 64'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_done: got seen=%b ov=%b data=%h rdy=%b want 1 0 0 1",
                     seen, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] key, data, res, back, exp;
        logic dcr;
        int lat;
        bit tmo;
        for (int v = 0; v < 8; v++) begin
            key = {$urandom, $urandom};
            data = {$urandom, $urandom};
            dcr = 1'($urandom_range(0, 1));
            exp = des_model(key, data, dcr);
            drive_block(key, data, dcr, res, lat, tmo);
            vectors++;
            if (tmo || res !== exp || lat != 16) begin
                miscompares++;
                $display("FAIL rand%0d: got %h lat=%0d want %h lat=16 (key %h data %h dec %b)",
                         v, res, lat, exp, key, data, dcr);
            end
            drive_block(key, res, ~dcr, back, lat, tmo);
            vectors++;
            if (tmo || back !== data) begin
                miscompares++;
                $display("FAIL rand%0d_roundtrip: got %h want %h", v, back, data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_reset_done();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
